vco_cal_sequencer: RTL and testbench
====================================

// Module: vco_cal_sequencer
// PURPOSE
//  Calibration sequencer for the two-VCO backend datapath.
//  - On i_start: holds the amplifier and VCO resets, releases them, then measures both VCO edge rates.
//  - Steps the amplifier-1 gain code until the two rates match within a tolerance.
//  - Reports the result with o_ready.
//  - Single clock domain: VCO edges arrive as i_clk-synchronous single-cycle pulses.
// PARAMETERS
//  WIN_CYCLES     1024  measurement window length, i_clk cycles (>=2)
//  SETTLE_CYCLES  16    reset-hold and post-release/post-step settle length, cycles (>=1)
//  CNT_W          12    pulse counter width; counters saturate at 2^CNT_W-1
//  TOL            2     max |cnt1-cnt2| accepted as matched
// PORTS
//  i_clk          in   1  system clock, all logic on rising edge
//  i_resetAll     in   1  synchronous, active-high reset
//  i_start        in   1  start calibration; sampled only in IDLE or DONE
//  i_vco1_pulse   in   1  one-cycle pulse per VCO1 edge (already synchronised)
//  i_vco2_pulse   in   1  one-cycle pulse per VCO2 edge (already synchronised)
//  i_gain2_cfg    in   2  amplifier-2 gain, loaded into o_gainA2 on accepted start
//  o_busy         out  1  high in every state except IDLE/DONE
//  o_ready        out  1  calibration complete; held until next start or reset
//  o_vco1_fast    out  1  result of last compare: 1 = cnt1 > cnt2 + TOL
//  o_resetb1      out  1  amplifier-1 reset, active low
//  o_resetb2      out  1  amplifier-2 reset, active low
//  o_resetbvco1   out  1  VCO1 reset, active low
//  o_resetbvco2   out  1  VCO2 reset, active low
//  o_gainA1       out  3  amplifier-1 gain code
//  o_gainA2       out  2  amplifier-2 gain code
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state=IDLE; o_busy=0; o_ready=0; o_vco1_fast=0.
//    All four resetb=0; o_gainA1=3'd4; o_gainA2=2'd0; counters=0; timer=0.
//  - Reset asserted in any state returns everything to reset values at the next edge; no partial result is kept.
//  - FSM states: IDLE, RST_HOLD, SETTLE, MEASURE, COMPARE, DONE.
//  - IDLE/DONE + i_start=1:
//      -> RST_HOLD; o_ready=0; o_vco1_fast=0; o_gainA1=3'd4; o_gainA2=i_gain2_cfg.
//  - i_start in any other state is ignored.
//  - RST_HOLD: all four resetb=0 for SETTLE_CYCLES cycles, then -> SETTLE with all resetb=1.
//    Resets stay released until the next start or reset.
//  - SETTLE: wait SETTLE_CYCLES cycles, then -> MEASURE with both counters cleared.
//  - MEASURE: exactly WIN_CYCLES cycles.
//    - Each cycle, cnt1 += i_vco1_pulse and cnt2 += i_vco2_pulse, saturating.
//    - Simultaneous pulses are both counted.
//    - Pulses outside MEASURE are ignored.
//  - COMPARE (1 cycle):
//    - |cnt1-cnt2| <= TOL: o_vco1_fast=0 -> DONE.
//    - cnt1 > cnt2: o_vco1_fast=1; o_gainA1>0 ? decrement, -> SETTLE : -> DONE.
//    - cnt1 < cnt2: o_vco1_fast=0; o_gainA1<7 ? increment, -> SETTLE : -> DONE.
//    - Gain code never wraps. Compare uses CNT_W+1-bit signed difference.
//  - DONE: o_ready=1 and o_busy=0; gain codes held.
//  - Latency, no gain step: o_ready rises 2*SETTLE_CYCLES+WIN_CYCLES+2 edges after the i_start sample edge.
//  - Each gain step adds SETTLE_CYCLES+WIN_CYCLES+1 cycles. Maximum 4 steps from midscale.
// TESTING  (SETTLE_CYCLES=4, WIN_CYCLES=64, TOL=2, CNT_W=12 unless noted)
//  - Both pulses every 4 cycles, start=1 for 1 cycle
//    -> cnt1=cnt2=16; gainA1 stays 4; vco1_fast=0; o_ready=1 exactly 74 edges after start.
//    -> resetb* low for cycles 1-4, high thereafter.
//  - vco1 pulse every 2 cycles, vco2 every 4
//    -> vco1_fast=1; gainA1 goes 4,3,2,1,0; DONE with gainA1=0.
//    -> o_ready at 74+4*69=350 edges.
//  - vco1 every 4 cycles, vco2 every 2
//    -> gainA1 goes 4,5,6,7; DONE with gainA1=7; vco1_fast=0.
//  - i_resetAll=1 for one cycle mid-MEASURE
//    -> next edge: busy=0, all resetb=0, gainA1=4, ready=0; later start completes normally.
//  - i_start during SETTLE is ignored (no extra restart).
//    - start in DONE with i_gain2_cfg=2'b11 -> restart; ready drops next edge; gainA2=3.
//  - CNT_W=4, vco1 pulse every cycle, vco2 none -> cnt1 saturates at 15, no wrap; vco1_fast=1.

Source files
------------

// File: rtl/vco_cal_sequencer.sv
// -----------------------------------------------------------------------------
// vco_cal_sequencer
// Calibration sequencer for the two-VCO backend datapath. A start request
// holds the amplifier and VCO resets, releases them, lets the loop settle and
// then counts VCO1/VCO2 edge pulses over a fixed window. The amplifier-1 gain
// code is stepped toward the side that balances the two rates until they
// match within TOL or the code hits its end stop, and the result is then
// reported with o_ready.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_resetAll     synchronous active-high reset
//   i_start        start calibration (honoured only in IDLE or DONE)
//   i_vco1_pulse   one-cycle pulse per VCO1 edge, i_clk synchronous
//   i_vco2_pulse   one-cycle pulse per VCO2 edge, i_clk synchronous
//   i_gain2_cfg    amplifier-2 gain, captured on an accepted start
//   o_busy         high while a calibration is in progress
//   o_ready        calibration complete, held until next start or reset
//   o_vco1_fast    last compare found cnt1 > cnt2 + TOL
//   o_resetb1/2    amplifier resets, active low
//   o_resetbvco1/2 VCO resets, active low
//   o_gainA1       amplifier-1 gain code (midscale 4)
//   o_gainA2       amplifier-2 gain code
// -----------------------------------------------------------------------------
module vco_cal_sequencer #(
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 12,
   parameter int TOL           = 2
) (
   input  logic       i_clk,
   input  logic       i_resetAll,
   input  logic       i_start,
   input  logic       i_vco1_pulse,
   input  logic       i_vco2_pulse,
   input  logic [1:0] i_gain2_cfg,
   output logic       o_busy,
   output logic       o_ready,
   output logic       o_vco1_fast,
   output logic       o_resetb1,
   output logic       o_resetb2,
   output logic       o_resetbvco1,
   output logic       o_resetbvco2,
   output logic [2:0] o_gainA1,
   output logic [1:0] o_gainA2
);

   // One timer is shared by reset-hold, settle and the measurement window.
   localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

   // Reset hold ends one count later than settle: the cycle in which the
   // start is accepted does not yet drive the resets low.
   localparam logic [TMR_W-1:0] HOLD_END    = TMR_W'(SETTLE_CYCLES);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

   localparam logic signed [CNT_W:0] TOL_S     = (CNT_W + 1)'(TOL);
   localparam logic signed [CNT_W:0] NEG_TOL_S = -((CNT_W + 1)'(TOL));

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RST_HOLD = 3'd1,
      S_SETTLE   = 3'd2,
      S_MEASURE  = 3'd3,
      S_COMPARE  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t                  state_r;
   logic [TMR_W-1:0]        timer_r;
   logic [CNT_W-1:0]        cnt1_r;
   logic [CNT_W-1:0]        cnt2_r;
   logic signed [CNT_W:0]   diff_s;
   logic                    vco1_fast_s;
   logic                    vco1_slow_s;

   // Saturating pulse counter step: an all-ones count never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             pulse);
      logic [CNT_W-1:0] res;
      if (pulse && (cnt != {CNT_W{1'b1}})) begin
         res = cnt + CNT_W'(1);
      end else begin
         res = cnt;
      end
      return res;
   endfunction

   // Rate comparison on a sign-extended difference so cnt1 < cnt2 is exact.
   always_comb begin
      diff_s      = $signed({1'b0, cnt1_r}) - $signed({1'b0, cnt2_r});
      vco1_fast_s = 1'b0;
      vco1_slow_s = 1'b0;
      if (diff_s > TOL_S) begin
         vco1_fast_s = 1'b1;
      end else if (diff_s < NEG_TOL_S) begin
         vco1_slow_s = 1'b1;
      end else begin
         vco1_fast_s = 1'b0;
         vco1_slow_s = 1'b0;
      end
   end

   // Calibration FSM with all outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_resetAll) begin
         state_r      <= S_IDLE;
         timer_r      <= '0;
         cnt1_r       <= '0;
         cnt2_r       <= '0;
         o_busy       <= 1'b0;
         o_ready      <= 1'b0;
         o_vco1_fast  <= 1'b0;
         o_resetb1    <= 1'b0;
         o_resetb2    <= 1'b0;
         o_resetbvco1 <= 1'b0;
         o_resetbvco2 <= 1'b0;
         o_gainA1     <= 3'd4;
         o_gainA2     <= 2'd0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  state_r     <= S_RST_HOLD;
                  timer_r     <= '0;
                  o_busy      <= 1'b1;
                  o_ready     <= 1'b0;
                  o_vco1_fast <= 1'b0;
                  o_gainA1    <= 3'd4;
                  o_gainA2    <= i_gain2_cfg;
               end
            end

            S_RST_HOLD: begin
               if (timer_r == HOLD_END) begin
                  state_r      <= S_SETTLE;
                  timer_r      <= '0;
                  o_resetb1    <= 1'b1;
                  o_resetb2    <= 1'b1;
                  o_resetbvco1 <= 1'b1;
                  o_resetbvco2 <= 1'b1;
               end else begin
                  timer_r      <= timer_r + TMR_ONE;
                  o_resetb1    <= 1'b0;
                  o_resetb2    <= 1'b0;
                  o_resetbvco1 <= 1'b0;
                  o_resetbvco2 <= 1'b0;
               end
            end

            S_SETTLE: begin
               if (timer_r == SETTLE_LAST) begin
                  state_r <= S_MEASURE;
                  timer_r <= '0;
                  cnt1_r  <= '0;
                  cnt2_r  <= '0;
               end else begin
                  timer_r <= timer_r + TMR_ONE;
               end
            end

            S_MEASURE: begin
               cnt1_r <= sat_inc(cnt1_r, i_vco1_pulse);
               cnt2_r <= sat_inc(cnt2_r, i_vco2_pulse);
               if (timer_r == WIN_LAST) begin
                  state_r <= S_COMPARE;
                  timer_r <= '0;
               end else begin
                  timer_r <= timer_r + TMR_ONE;
               end
            end

            S_COMPARE: begin
               timer_r <= '0;
               if (vco1_fast_s) begin
                  o_vco1_fast <= 1'b1;
                  if (o_gainA1 != 3'd0) begin
                     o_gainA1 <= o_gainA1 - 3'd1;
                     state_r  <= S_SETTLE;
                  end else begin
                     state_r  <= S_DONE;
                     o_busy   <= 1'b0;
                     o_ready  <= 1'b1;
                  end
               end else if (vco1_slow_s) begin
                  o_vco1_fast <= 1'b0;
                  if (o_gainA1 != 3'd7) begin
                     o_gainA1 <= o_gainA1 + 3'd1;
                     state_r  <= S_SETTLE;
                  end else begin
                     state_r  <= S_DONE;
                     o_busy   <= 1'b0;
                     o_ready  <= 1'b1;
                  end
               end else begin
                  o_vco1_fast <= 1'b0;
                  state_r     <= S_DONE;
                  o_busy      <= 1'b0;
                  o_ready     <= 1'b1;
               end
            end

            default: begin
               state_r <= S_IDLE;
               timer_r <= '0;
               o_busy  <= 1'b0;
               o_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vco_cal_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vco_cal_sequencer
// Scoreboard bench for vco_cal_sequencer. Instance A uses CNT_W=12, instance B
// uses CNT_W=4 to exercise counter saturation. Both use SETTLE_CYCLES=4,
// WIN_CYCLES=64, TOL=2, so a calibration with no gain step completes 74 edges
// after the start edge and each gain step adds 69 edges.
// -----------------------------------------------------------------------------
module tb_vco_cal_sequencer;

   localparam int BASE_LAT = 74;
   localparam int STEP_LAT = 69;

   typedef struct {
      int         edge_no;
      logic [2:0] g1;
      logic [1:0] g2;
      logic       fast;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       vco1 = 1'b0;
   logic       vco2 = 1'b0;
   logic [1:0] cfg = 2'd0;

   logic       busy_a, ready_a, fast_a, rb1_a, rb2_a, rbv1_a, rbv2_a;
   logic [2:0] g1_a;
   logic [1:0] g2_a;
   logic       busy_b, ready_b, fast_b, rb1_b, rb2_b, rbv1_b, rbv2_b;
   logic [2:0] g1_b;
   logic [1:0] g2_b;

   int   cyc = 0;
   int   p1 = 0;
   int   p2 = 0;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   vco_cal_sequencer #(.WIN_CYCLES(64), .SETTLE_CYCLES(4), .CNT_W(12), .TOL(2)) u_a (
      .i_clk(clk), .i_resetAll(rst), .i_start(start_a),
      .i_vco1_pulse(vco1), .i_vco2_pulse(vco2), .i_gain2_cfg(cfg),
      .o_busy(busy_a), .o_ready(ready_a), .o_vco1_fast(fast_a),
      .o_resetb1(rb1_a), .o_resetb2(rb2_a), .o_resetbvco1(rbv1_a), .o_resetbvco2(rbv2_a),
      .o_gainA1(g1_a), .o_gainA2(g2_a));

   vco_cal_sequencer #(.WIN_CYCLES(64), .SETTLE_CYCLES(4), .CNT_W(4), .TOL(2)) u_b (
      .i_clk(clk), .i_resetAll(rst), .i_start(start_b),
      .i_vco1_pulse(vco1), .i_vco2_pulse(vco2), .i_gain2_cfg(cfg),
      .o_busy(busy_b), .o_ready(ready_b), .o_vco1_fast(fast_b),
      .o_resetb1(rb1_b), .o_resetb2(rb2_b), .o_resetbvco1(rbv1_b), .o_resetbvco2(rbv2_b),
      .o_gainA1(g1_b), .o_gainA2(g2_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_total++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Pulse generator: period 0 means no pulses.
   initial begin
      forever begin
         @(negedge clk);
         vco1 = (p1 != 0) && ((cyc % p1) == 0);
         vco2 = (p2 != 0) && ((cyc % p2) == 0);
      end
   end

   // Monitor A: compare each rising o_ready against the scoreboard.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready_a && !prev) begin
            if (sb_a.size() == 0) begin
               fail("a_unexpected_ready");
            end else begin
               e = sb_a.pop_front();
               check("a_ready_edge", cyc, e.edge_no);
               check("a_gainA1", {29'd0, g1_a}, {29'd0, e.g1});
               check("a_gainA2", {30'd0, g2_a}, {30'd0, e.g2});
               check("a_vco1_fast", {31'd0, fast_a}, {31'd0, e.fast});
               check("a_busy_done", {31'd0, busy_a}, 32'd0);
            end
         end
         prev = ready_a;
      end
   end

   // Monitor B: same for the narrow-counter instance.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready_b && !prev) begin
            if (sb_b.size() == 0) begin
               fail("b_unexpected_ready");
            end else begin
               e = sb_b.pop_front();
               check("b_ready_edge", cyc, e.edge_no);
               check("b_gainA1", {29'd0, g1_b}, {29'd0, e.g1});
               check("b_vco1_fast", {31'd0, fast_b}, {31'd0, e.fast});
            end
         end
         prev = ready_b;
      end
   end

   // Pulse start for one edge; s returns the index of the sampling edge.
   task automatic do_start(input logic sel_b, input logic [1:0] c, output int s);
      @(negedge clk);
      cfg = c;
      if (sel_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      s = cyc;
   endtask

   task automatic push(input logic sel_b, input int s, input int steps,
                       input logic [2:0] g1, input logic [1:0] g2, input logic fast);
      exp_t e;
      e.edge_no = s + BASE_LAT + steps * STEP_LAT;
      e.g1      = g1;
      e.g2      = g2;
      e.fast    = fast;
      if (sel_b) sb_b.push_back(e);
      else       sb_a.push_back(e);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (((sb_a.size() != 0) || (sb_b.size() != 0)) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) fail(name);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int s;
      int s2;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_ready", {31'd0, ready_a}, 32'd0);
      check("rst_fast", {31'd0, fast_a}, 32'd0);
      check("rst_resetb", {28'd0, rb1_a, rb2_a, rbv1_a, rbv2_a}, 32'd0);
      check("rst_gainA1", {29'd0, g1_a}, 32'd4);
      check("rst_gainA2", {30'd0, g2_a}, 32'd0);
      rst = 1'b0;

      // Matched rates: no step
      p1 = 4; p2 = 4;
      do_start(1'b0, 2'd1, s);
      push(1'b0, s, 0, 3'd4, 2'd1, 1'b0);
      wait_done("t1_timeout");

      // VCO1 fast: four decrements to the floor; resets checked on a restart from DONE
      p1 = 2; p2 = 4;
      do_start(1'b0, 2'd2, s);
      push(1'b0, s, 4, 3'd0, 2'd2, 1'b1);
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("resetb_cycle%0d", k), {28'd0, rb1_a, rb2_a, rbv1_a, rbv2_a},
               (k <= 4) ? 32'd0 : 32'd15);
      end
      wait_done("t2_timeout");

      // VCO1 slow: three increments to the ceiling
      p1 = 4; p2 = 2;
      do_start(1'b0, 2'd0, s);
      push(1'b0, s, 3, 3'd7, 2'd0, 1'b0);
      wait_done("t3_timeout");

      // Reset mid-MEASURE, then a clean run
      p1 = 2; p2 = 4;
      do_start(1'b0, 2'd3, s);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
      check("midrst_resetb", {28'd0, rb1_a, rb2_a, rbv1_a, rbv2_a}, 32'd0);
      check("midrst_gainA1", {29'd0, g1_a}, 32'd4);
      check("midrst_gainA2", {30'd0, g2_a}, 32'd0);
      check("midrst_ready", {31'd0, ready_a}, 32'd0);
      rst = 1'b0;
      p1 = 4; p2 = 4;
      do_start(1'b0, 2'd1, s);
      push(1'b0, s, 0, 3'd4, 2'd1, 1'b0);
      wait_done("t4_timeout");

      // Start during SETTLE is ignored: latency still counts from the first start
      do_start(1'b0, 2'd0, s);
      push(1'b0, s, 0, 3'd4, 2'd0, 1'b0);
      while (cyc < s + 6) @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      wait_done("t5_timeout");

      // Restart from DONE with gain2 config 3
      do_start(1'b0, 2'd3, s2);
      push(1'b0, s2, 0, 3'd4, 2'd3, 1'b0);
      @(negedge clk);
      check("restart_ready_drop", {31'd0, ready_a}, 32'd0);
      check("restart_busy", {31'd0, busy_a}, 32'd1);
      check("restart_gainA2", {30'd0, g2_a}, 32'd3);
      wait_done("t6_timeout");

      // Narrow counter: cnt1 saturates at 15 instead of wrapping to 0
      p1 = 1; p2 = 0;
      do_start(1'b1, 2'd0, s);
      push(1'b1, s, 4, 3'd0, 2'd0, 1'b1);
      wait_done("t7_timeout");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
